sensor_sync_filter: RTL and testbench

Parametrised input conditioner for the line-follower sensor inputs. Each of N_CH asynchronous sensor lines passes through a SYNC_STAGES-deep synchroniser and then a per-channel debounce filter. The filter only changes an output after the synchronised input has held a new value for FILTER_CNT consecutive cycles. It sits between the sensor pins and the controller FSM, and also gives the FSM one-cycle rise/fall pulses, a bypass mode and a global stability flag.

---
 rtl/sensor_sync_filter.sv | 112 +++++++++++
 tb/tb_sensor_sync_filter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_sync_filter.sv
// ---------------------------------------------------------------------------
// sensor_sync_filter
//
// Input conditioner for the line-follower sensor lines. Each channel has a
// SYNC_STAGES-deep synchroniser followed by a debounce filter. A filtered
// output only changes after the synchronised input has held a new value for
// FILTER_CNT consecutive cycles. With filter_en low the filter is bypassed
// and the output follows the synchroniser with one register of delay.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset (released synchronously)
//   sensor_in  - raw asynchronous sensor levels [N_CH]
//   filter_en  - 1 = debounce active, 0 = bypass (synchronous to clk)
//   sensor_out - filtered sensor levels [N_CH]
//   rise       - one-cycle pulse when sensor_out[i] goes 0->1 [N_CH]
//   fall       - one-cycle pulse when sensor_out[i] goes 1->0 [N_CH]
//   stable     - 1 when every synchronised input equals its sensor_out
// ---------------------------------------------------------------------------
module sensor_sync_filter #(
  parameter int N_CH        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] sensor_in,
  input  logic            filter_en,
  output logic [N_CH-1:0] sensor_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            stable
);

  localparam int CNT_W = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

  // Synchroniser chain: plain flop-to-flop, nothing in between.
  logic [N_CH-1:0] r_sync [SYNC_STAGES];
  logic [N_CH-1:0] w_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync[0] <= '0;
    end else begin
      r_sync[0] <= sensor_in;
    end
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync[gi] <= '0;
      end else begin
        r_sync[gi] <= r_sync[gi-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Per-channel debounce filter and edge pulses.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_out;
    logic             w_out_next;
    logic             r_rise;
    logic             r_fall;

    // Any cycle where sync matches the output (or bypass is selected)
    // drops the count back to zero, so only an unbroken run of
    // FILTER_CNT differing samples can flip the output.
    always_comb begin
      w_cnt_next = '0;
      w_out_next = r_out;
      if (!filter_en) begin
        w_out_next = w_sync[gi];
      end else if (w_sync[gi] != r_out) begin
        if (r_cnt == CNT_LAST) begin
          w_out_next = w_sync[gi];
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_next;
        r_out  <= w_out_next;
        // Registered alongside r_out so the pulse lines up with the
        // first cycle the new level is visible.
        r_rise <= w_out_next & ~r_out;
        r_fall <= ~w_out_next & r_out;
      end
    end

    assign sensor_out[gi] = r_out;
    assign rise[gi]       = r_rise;
    assign fall[gi]       = r_fall;
  end

  // Combinational; reads 1 in reset because sync and outputs are all 0.
  assign stable = &(~(w_sync ^ sensor_out));

endmodule

// File: tb/tb_sensor_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_sensor_sync_filter
//
// Drives sensor_sync_filter with directed sequences and random stimulus and
// compares every cycle against a reference model that works from the sample
// history: sync is the input delayed by the synchroniser depth, and an output
// flips when the last FILTER_CNT sync samples all differed from it with the
// filter enabled throughout.
// ---------------------------------------------------------------------------
module tb_sensor_sync_filter;

  localparam int N_CH        = 3;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_CNT  = 4;
  // Edge (counted from release) at which a constant input first shows.
  localparam int FULL_LAT    = SYNC_STAGES + FILTER_CNT;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N_CH-1:0] sensor_in = '0;
  logic            filter_en = 1'b1;
  logic [N_CH-1:0] sensor_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            stable;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;

  sensor_sync_filter #(
    .N_CH       (N_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_CNT (FILTER_CNT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sensor_in (sensor_in),
    .filter_en (filter_en),
    .sensor_out(sensor_out),
    .rise      (rise),
    .fall      (fall),
    .stable    (stable)
  );

  always #5 clk = ~clk;

  // Reference model state: history of samples taken since reset release.
  logic [N_CH-1:0] in_q[$];
  bit              en_q[$];
  logic [N_CH-1:0] m_out  = '0;
  logic [N_CH-1:0] m_rise = '0;
  logic [N_CH-1:0] m_fall = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", tag, n_step, got, exp);
    end
  endtask

  // Value held by the last synchroniser stage just before edge idx (0-based).
  function automatic logic [N_CH-1:0] sync_before(input int idx);
    if (idx - SYNC_STAGES < 0) return '0;
    return in_q[idx - SYNC_STAGES];
  endfunction

  task automatic model_edge();
    logic [N_CH-1:0] nxt;
    logic [N_CH-1:0] s;
    int              n;
    int              idx;
    bit              all_diff;
    in_q.push_back(sensor_in);
    en_q.push_back(filter_en);
    n   = in_q.size();
    nxt = m_out;
    for (int c = 0; c < N_CH; c++) begin
      if (!filter_en) begin
        s      = sync_before(n - 1);
        nxt[c] = s[c];
      end else begin
        all_diff = 1'b1;
        for (int j = 0; j < FILTER_CNT; j++) begin
          idx = n - 1 - j;
          if (idx < 0 || !en_q[idx]) begin
            all_diff = 1'b0;
          end else begin
            s = sync_before(idx);
            if (s[c] == m_out[c]) all_diff = 1'b0;
          end
        end
        if (all_diff) nxt[c] = ~m_out[c];
      end
    end
    m_rise = nxt & ~m_out;
    m_fall = ~nxt & m_out;
    m_out  = nxt;
  endtask

  function automatic logic model_stable();
    int              n;
    logic [N_CH-1:0] s;
    n = in_q.size();
    s = (n - SYNC_STAGES >= 0) ? in_q[n - SYNC_STAGES] : '0;
    return (s == m_out);
  endfunction

  // One clock: apply inputs, advance model on the edge, compare at negedge.
  task automatic step(input logic [N_CH-1:0] in, input logic en);
    sensor_in = in;
    filter_en = en;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    n_step++;
    check("sensor_out", 32'(sensor_out), 32'(m_out));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("stable", 32'(stable), 32'(model_stable()));
    $display("step %0d in=%b en=%b out=%b rise=%b fall=%b stable=%b",
             n_step, in, en, sensor_out, rise, fall, stable);
  endtask

  task automatic do_reset(input logic [N_CH-1:0] in);
    sensor_in = in;
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_now", 32'(sensor_out), 32'd0);
    check("rst_rise_now", 32'(rise), 32'd0);
    check("rst_fall_now", 32'(fall), 32'd0);
    in_q.delete();
    en_q.delete();
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_held", 32'(sensor_out), 32'd0);
    check("rst_stable", 32'(stable), 32'd1);
    $display("reset in=%b out=%b rise=%b fall=%b stable=%b",
             in, sensor_out, rise, fall, stable);
    reset_n = 1'b1;
  endtask

  // From a freshly released reset with a constant input: finds the first
  // step at which sensor_out shows it and checks the rise pulse is one cycle.
  task automatic measure_latency(input logic [N_CH-1:0] in, input string tag);
    int first;
    first = -1;
    for (int k = 1; k <= FULL_LAT + 3; k++) begin
      step(in, 1'b1);
      if (first < 0 && sensor_out == in) begin
        first = k;
        check({tag, "_rise"}, 32'(rise), 32'(in));
      end else if (first > 0) begin
        check({tag, "_rise_off"}, 32'(rise), 32'd0);
      end
    end
    check(tag, 32'(first), 32'(FULL_LAT));
  endtask

  initial begin
    logic [N_CH-1:0] cur;
    logic            en_cur;

    do_reset(3'b111);
    measure_latency(3'b111, "lat_after_reset");
    for (int k = 0; k < 8; k++) step(3'b000, 1'b1);

    // Step and hold on channel 0, then release.
    for (int k = 0; k < 8; k++) step(3'b001, 1'b1);
    for (int k = 0; k < 8; k++) step(3'b000, 1'b1);

    // Glitches on channel 1: 3 cycles (rejected) then 4 cycles (passes).
    for (int k = 0; k < 3; k++) step(3'b010, 1'b1);
    for (int k = 0; k < 8; k++) step(3'b000, 1'b1);
    for (int k = 0; k < 4; k++) step(3'b010, 1'b1);
    for (int k = 0; k < 10; k++) step(3'b000, 1'b1);

    // Restart on channel 2: 1,1,1,0,1,1,1,1.
    for (int k = 0; k < 3; k++) step(3'b100, 1'b1);
    step(3'b000, 1'b1);
    for (int k = 0; k < 8; k++) step(3'b100, 1'b1);
    for (int k = 0; k < 8; k++) step(3'b000, 1'b1);

    // Bypass with channel 0 toggling every cycle.
    for (int k = 0; k < 10; k++) step((k % 2 == 0) ? 3'b001 : 3'b000, 1'b0);
    // Back to filter mode while channel 0 is mid-change.
    step(3'b001, 1'b0);
    for (int k = 0; k < 3; k++) step(3'b001, 1'b1);
    step(3'b001, 1'b0);
    for (int k = 0; k < 2; k++) step(3'b000, 1'b1);
    for (int k = 0; k < 8; k++) step(3'b000, 1'b1);

    // Reset while channel 0 has a partial count.
    for (int k = 0; k < 4; k++) step(3'b001, 1'b1);
    do_reset(3'b001);
    measure_latency(3'b001, "lat_after_midreset");

    // Random stimulus with slowly changing levels and occasional bypass.
    cur    = 3'b001;
    en_cur = 1'b1;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      end
      if ($urandom_range(0, 30) == 0) en_cur = ~en_cur;
      if (i == 250) do_reset(cur);
      step(cur, en_cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
